// File: rtl/bp_pkg.sv
// Shared constants and types for the fetch-stage branch predictor:
// MIPS opcode/function codes and the EX-to-IF resolution bundle.
package bp_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    // Widest pattern table the resolution bundle can address.
    localparam int MAX_INDEX_BITS = 16;

    typedef struct packed {
        logic [MAX_INDEX_BITS-1:0] index;
        logic                      taken;
        logic                      pred_taken;
    } bp_resolve_t;

    function automatic logic is_cond_branch(input logic [5:0] opcode);
        return (opcode == OP_BEQ) || (opcode == OP_BNE);
    endfunction

    function automatic logic is_direct_jump(input logic [5:0] opcode);
        return (opcode == OP_J) || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Array of saturating counters: one combinational read port and one
// clocked read-modify-write port that counts up on taken, down otherwise.
module sat_counter_table #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int INIT_CTR   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [CTR_BITS-1:0]   rd_ctr,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_taken
);

    localparam int                 DEPTH    = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);

    logic [CTR_BITS-1:0] ctr [DEPTH];
    logic [CTR_BITS-1:0] wr_old;

    // No bypass: a same-cycle write to rd_index is visible only after the edge.
    assign rd_ctr = ctr[rd_index];
    assign wr_old = ctr[wr_index];

    // NOTE: the table is reset as a whole because every entry must start at
    // INIT_CTR; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                if (wr_old != CTR_MAX) ctr[wr_index] <= wr_old + CTR_BITS'(1);
            end else begin
                if (wr_old != '0) ctr[wr_index] <= wr_old - CTR_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/sign_extension.sv
// Sign-extends a 16-bit immediate to 32 bits.
module sign_extension (
    input  logic [15:0] imm,
    output logic [31:0] imm_ext
);

    assign imm_ext = {{16{imm[15]}}, imm};

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage PC decoder with a bimodal/gshare conditional-branch predictor,
// trained non-speculatively from EX, plus branch/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 6,
    parameter int GSHARE     = 0,
    parameter int INIT_CTR   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc,
    input  logic [31:0]           instr,
    output logic [31:0]           pc_plus_4,
    output logic [31:0]           pc_next,
    output logic                  is_branch,
    output logic                  is_jump,
    output logic                  is_jump_reg,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_pred_taken,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);

    if (HIST_BITS > INDEX_BITS) begin : g_bad_hist
        $error("branch_predictor: HIST_BITS (%0d) must not exceed INDEX_BITS (%0d)",
               HIST_BITS, INDEX_BITS);
    end
    if (INDEX_BITS > MAX_INDEX_BITS) begin : g_bad_index
        $error("branch_predictor: INDEX_BITS (%0d) exceeds MAX_INDEX_BITS", INDEX_BITS);
    end
    if (CTR_BITS < 1 || HIST_BITS < 1) begin : g_bad_width
        $error("branch_predictor: CTR_BITS and HIST_BITS must be at least 1");
    end

    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic [31:0]          imm_ext;
    logic [31:0]          pc_jump;
    logic [31:0]          pc_branch;
    logic [HIST_BITS-1:0] ghr;
    logic [CTR_BITS-1:0]  rd_ctr;
    bp_resolve_t          res;
    logic                 wr_en;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    sign_extension u_sign_ext (
        .imm     (instr[15:0]),
        .imm_ext (imm_ext)
    );

    assign pc_plus_4 = pc + 32'd4;
    assign pc_jump   = {pc_plus_4[31:28], instr[25:0], 2'b00};
    assign pc_branch = pc_plus_4 + (imm_ext << 2);

    // History only folds into the index in gshare mode; it is kept either way.
    assign pred_index = pc[INDEX_BITS+1:2]
                      ^ ((GSHARE != 0) ? INDEX_BITS'(ghr) : '0);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        is_jump_reg = 1'b0;
        pred_taken  = 1'b0;
        pc_next     = pc_plus_4;
        if (is_cond_branch(opcode)) begin
            is_branch  = 1'b1;
            pred_taken = rd_ctr[CTR_BITS-1];
            if (rd_ctr[CTR_BITS-1]) pc_next = pc_branch;
        end else if (is_direct_jump(opcode)) begin
            is_jump = 1'b1;
            pc_next = pc_jump;
        end else if (opcode == OP_RTYPE && funct == FUNC_JR) begin
            is_jump_reg = 1'b1;
        end
    end

    assign res = '{index:      MAX_INDEX_BITS'(upd_index),
                   taken:      upd_taken,
                   pred_taken: upd_pred_taken};

    // An index outside this table's range is never written.
    assign wr_en = upd_en && ((res.index >> INDEX_BITS) == '0);

    sat_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS),
        .INIT_CTR   (INIT_CTR)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (pred_index),
        .rd_ctr   (rd_ctr),
        .wr_en    (wr_en),
        .wr_index (res.index[INDEX_BITS-1:0]),
        .wr_taken (res.taken)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr            <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (upd_en) begin
            ghr            <= HIST_BITS'({ghr, res.taken});
            branch_cnt     <= branch_cnt + 32'd1;
            mispredict_cnt <= mispredict_cnt + 32'(res.taken != res.pred_taken);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: a bimodal and a gshare predictor share stimulus and
// are compared against an arithmetic reference model of the predictor rules.
module tb_branch_predictor;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] pc_next;
        logic        is_branch;
        logic        is_jump;
        logic        is_jump_reg;
        logic        pred_taken;
        logic [5:0]  pred_index;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        upd_en = 1'b0;
    logic [5:0]  upd_index = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred_taken = 1'b0;

    logic [31:0] pc_plus_4_b, pc_next_b, branch_cnt_b, mispredict_cnt_b;
    logic        is_branch_b, is_jump_b, is_jump_reg_b, pred_taken_b;
    logic [5:0]  pred_index_b;
    logic [31:0] pc_plus_4_g, pc_next_g, branch_cnt_g, mispredict_cnt_g;
    logic        is_branch_g, is_jump_g, is_jump_reg_g, pred_taken_g;
    logic [5:0]  pred_index_g;

    int n_vec  = 0;
    int n_fail = 0;

    int          m_ctr_b [64];
    int          m_ctr_g [64];
    int          m_ghr;
    logic [31:0] m_bcnt, m_mcnt;

    always #5 clk = ~clk;

    branch_predictor #(.GSHARE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
        .pc_plus_4(pc_plus_4_b), .pc_next(pc_next_b),
        .is_branch(is_branch_b), .is_jump(is_jump_b), .is_jump_reg(is_jump_reg_b),
        .pred_taken(pred_taken_b), .pred_index(pred_index_b),
        .upd_en(upd_en), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken),
        .branch_cnt(branch_cnt_b), .mispredict_cnt(mispredict_cnt_b)
    );

    branch_predictor #(.GSHARE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
        .pc_plus_4(pc_plus_4_g), .pc_next(pc_next_g),
        .is_branch(is_branch_g), .is_jump(is_jump_g), .is_jump_reg(is_jump_reg_g),
        .pred_taken(pred_taken_g), .pred_index(pred_index_g),
        .upd_en(upd_en), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken),
        .branch_cnt(branch_cnt_g), .mispredict_cnt(mispredict_cnt_g)
    );

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_ctr_b[i] = 1;
            m_ctr_g[i] = 1;
        end
        m_ghr  = 0;
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic void model_update(input int idx, input bit taken, input bit pred);
        if (taken) begin
            m_ctr_b[idx] = (m_ctr_b[idx] < 3) ? m_ctr_b[idx] + 1 : 3;
            m_ctr_g[idx] = (m_ctr_g[idx] < 3) ? m_ctr_g[idx] + 1 : 3;
        end else begin
            m_ctr_b[idx] = (m_ctr_b[idx] > 0) ? m_ctr_b[idx] - 1 : 0;
            m_ctr_g[idx] = (m_ctr_g[idx] > 0) ? m_ctr_g[idx] - 1 : 0;
        end
        m_ghr  = (m_ghr * 2 + int'(taken)) % 64;
        m_bcnt = m_bcnt + 1;
        if (taken != pred) m_mcnt = m_mcnt + 1;
    endfunction

    function automatic exp_t model_lookup(input logic [31:0] p, input logic [31:0] ins, input bit g);
        exp_t e;
        int op, fn, idx, c, imm;
        op  = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        imm = int'($signed(ins[15:0]));
        e.pc_plus_4   = p + 32'd4;
        e.is_branch   = (op == 4) || (op == 5);
        e.is_jump     = (op == 2) || (op == 3);
        e.is_jump_reg = (op == 0) && (fn == 8);
        idx = int'((p / 4) % 64);
        if (g) idx = idx ^ m_ghr;
        c = g ? m_ctr_g[idx] : m_ctr_b[idx];
        e.pred_index = 6'(idx);
        e.pred_taken = e.is_branch && (c >= 2);
        if (e.is_jump)
            e.pc_next = {e.pc_plus_4[31:28], ins[25:0], 2'b00};
        else if (e.pred_taken)
            e.pc_next = e.pc_plus_4 + 32'(imm * 4);
        else
            e.pc_next = e.pc_plus_4;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_update(input int idx, input bit taken, input bit pred);
        upd_en = 1'b1;
        upd_index = 6'(idx);
        upd_taken = taken;
        upd_pred_taken = pred;
        @(posedge clk);
        model_update(idx, taken, pred);
        #1;
        upd_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        pc = 32'h0040_0000;
        instr = 32'h1000_0003;
        #1;
        n_vec++;
        if ({is_branch_b, pred_taken_b, pc_next_b} !== {1'b1, 1'b0, 32'h0040_0004}) begin
            n_fail++;
            $display("FAIL reset_lookup: got br=%b pt=%b next=%h expected br=1 pt=0 next=00400004",
                     is_branch_b, pred_taken_b, pc_next_b);
        end
        n_vec++;
        if ({branch_cnt_b, mispredict_cnt_b, pred_index_g} !== {32'd0, 32'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got bcnt=%0d mcnt=%0d gidx=%0d expected 0 0 0",
                     branch_cnt_b, mispredict_cnt_b, pred_index_g);
        end
    endtask

    task automatic test_training();
        pc = 32'h0040_0000;
        instr = 32'h1000_0003;
        apply_update(0, 1'b1, 1'b0);
        apply_update(0, 1'b1, 1'b0);
        #1;
        n_vec++;
        if ({pred_taken_b, pc_next_b} !== {1'b1, 32'h0040_0010}) begin
            n_fail++;
            $display("FAIL train_taken: got pt=%b next=%h expected pt=1 next=00400010",
                     pred_taken_b, pc_next_b);
        end
        apply_update(0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) apply_update(0, 1'b0, 1'b1);
        #1;
        n_vec++;
        if ({pred_taken_b, pc_next_b} !== {1'b0, 32'h0040_0004}) begin
            n_fail++;
            $display("FAIL train_not_taken: got pt=%b next=%h expected pt=0 next=00400004",
                     pred_taken_b, pc_next_b);
        end
        // From 0, one more not-taken must hold at 0: then two takens are needed.
        apply_update(0, 1'b0, 1'b0);
        apply_update(0, 1'b1, 1'b0);
        #1;
        n_vec++;
        if (pred_taken_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_low: got pt=%b expected pt=0", pred_taken_b);
        end
        apply_update(0, 1'b1, 1'b0);
        #1;
        n_vec++;
        if (pred_taken_b !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_low_recover: got pt=%b expected pt=1", pred_taken_b);
        end
    endtask

    task automatic test_jumps();
        // Counter 0 is taken-biased (value 2) after test_training.
        pc = 32'h1000_0000;
        instr = 32'h0800_0010;
        #1;
        n_vec++;
        if ({is_jump_b, is_branch_b, is_jump_reg_b, pc_next_b} !== {3'b100, 32'h1000_0040}) begin
            n_fail++;
            $display("FAIL jump: got j=%b br=%b jr=%b next=%h expected 1 0 0 10000040",
                     is_jump_b, is_branch_b, is_jump_reg_b, pc_next_b);
        end
        pc = 32'h0040_0100;
        instr = 32'h03E0_0008;
        #1;
        n_vec++;
        if ({is_jump_reg_b, is_jump_b, is_branch_b, pred_taken_b, pc_next_b}
                !== {4'b1000, 32'h0040_0104}) begin
            n_fail++;
            $display("FAIL jr: got jr=%b j=%b br=%b pt=%b next=%h expected 1 0 0 0 00400104",
                     is_jump_reg_b, is_jump_b, is_branch_b, pred_taken_b, pc_next_b);
        end
        pc = 32'h0040_0000;
        instr = 32'h1400_FFFF;
        #1;
        n_vec++;
        if ({is_branch_b, pred_taken_b, pc_next_b} !== {2'b11, 32'h0040_0000}) begin
            n_fail++;
            $display("FAIL bne_backward: got br=%b pt=%b next=%h expected 1 1 00400000",
                     is_branch_b, pred_taken_b, pc_next_b);
        end
        instr = 32'h8C00_0000;
        #1;
        n_vec++;
        if ({is_branch_b, is_jump_b, is_jump_reg_b, pred_taken_b, pc_next_b}
                !== {4'b0000, 32'h0040_0004}) begin
            n_fail++;
            $display("FAIL other_op: got br=%b j=%b jr=%b pt=%b next=%h expected 0 0 0 0 00400004",
                     is_branch_b, is_jump_b, is_jump_reg_b, pred_taken_b, pc_next_b);
        end
    endtask

    task automatic test_gshare();
        do_reset();
        apply_update(10, 1'b1, 1'b0);
        apply_update(10, 1'b0, 1'b0);
        apply_update(10, 1'b1, 1'b0);
        pc = 32'h0040_0000;
        instr = 32'h1000_0003;
        #1;
        n_vec++;
        if ({pred_index_g, pred_index_b} !== {6'd5, 6'd0}) begin
            n_fail++;
            $display("FAIL gshare_index: got g=%0d b=%0d expected g=5 b=0", pred_index_g, pred_index_b);
        end
        do_reset();
        #1;
        n_vec++;
        if (pred_index_g !== 6'd0) begin
            n_fail++;
            $display("FAIL gshare_index_reset: got %0d expected 0", pred_index_g);
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        do_reset();
        pc = 32'h0040_0050;
        instr = 32'h1000_0003;
        upd_en = 1'b1;
        upd_index = 6'd20;
        upd_taken = 1'b1;
        upd_pred_taken = 1'b0;
        #1;
        e = model_lookup(pc, instr, 1'b0);
        n_vec++;
        if (pred_taken_b !== e.pred_taken) begin
            n_fail++;
            $display("FAIL rw_same_cycle_old: got %b expected %b", pred_taken_b, e.pred_taken);
        end
        @(posedge clk);
        model_update(20, 1'b1, 1'b0);
        #1;
        upd_en = 1'b0;
        #1;
        e = model_lookup(pc, instr, 1'b0);
        n_vec++;
        if (pred_taken_b !== e.pred_taken) begin
            n_fail++;
            $display("FAIL rw_same_cycle_new: got %b expected %b", pred_taken_b, e.pred_taken);
        end
    endtask

    task automatic test_stats();
        do_reset();
        apply_update(3, 1'b1, 1'b1);
        apply_update(4, 1'b0, 1'b1);
        apply_update(5, 1'b0, 1'b0);
        apply_update(6, 1'b1, 1'b0);
        apply_update(7, 1'b1, 1'b1);
        n_vec++;
        if ({branch_cnt_b, mispredict_cnt_b} !== {32'd5, 32'd2}) begin
            n_fail++;
            $display("FAIL stats: got bcnt=%0d mcnt=%0d expected 5 2", branch_cnt_b, mispredict_cnt_b);
        end
        // Asynchronous reset mid-cycle, with an update pending at the inputs.
        upd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({branch_cnt_b, mispredict_cnt_b, branch_cnt_g} !== {32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL stats_async_reset: got bcnt=%0d mcnt=%0d gbcnt=%0d expected 0 0 0",
                     branch_cnt_b, mispredict_cnt_b, branch_cnt_g);
        end
        upd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        exp_t e, a;
        logic [31:0] r;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom();
            case ($urandom_range(0, 5))
                0: instr = {6'b000100, r[25:0]};
                1: instr = {6'b000101, r[25:0]};
                2: instr = {6'b000010, r[25:0]};
                3: instr = {6'b000011, r[25:0]};
                4: instr = {6'b000000, r[25:21], 15'd0, 6'b001000};
                default: instr = {6'b100011, r[25:0]};
            endcase
            pc = $urandom() & 32'hFFFF_FFFC;
            upd_en = ($urandom_range(0, 3) != 0);
            upd_index = 6'($urandom_range(0, 63));
            upd_taken = 1'($urandom_range(0, 1));
            upd_pred_taken = 1'($urandom_range(0, 1));
            #1;
            for (int g = 0; g < 2; g++) begin
                e = model_lookup(pc, instr, g[0]);
                if (g == 0)
                    a = '{pc_plus_4_b, pc_next_b, is_branch_b, is_jump_b, is_jump_reg_b,
                          pred_taken_b, pred_index_b};
                else
                    a = '{pc_plus_4_g, pc_next_g, is_branch_g, is_jump_g, is_jump_reg_g,
                          pred_taken_g, pred_index_g};
                n_vec++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL rand_lookup gshare=%0d pc=%h instr=%h: got %h expected %h",
                             g, pc, instr, a, e);
                end
            end
            @(posedge clk);
            if (upd_en) model_update(int'(upd_index), upd_taken, upd_pred_taken);
            #1;
            n_vec++;
            if ({branch_cnt_b, mispredict_cnt_b, branch_cnt_g, mispredict_cnt_g}
                    !== {m_bcnt, m_mcnt, m_bcnt, m_mcnt}) begin
                n_fail++;
                $display("FAIL rand_stats: got b=%0d/%0d g=%0d/%0d expected %0d/%0d",
                         branch_cnt_b, mispredict_cnt_b, branch_cnt_g, mispredict_cnt_g,
                         m_bcnt, m_mcnt);
            end
        end
        upd_en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_training();
        test_jumps();
        test_gshare();
        test_same_cycle();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
